// File: rtl/rr_arbiter_rts.sv
// ---------------------------------------------------------------------------
// rr_arbiter_rts
//   Round-robin output-port arbiter for the NoC router. One instance sits per
//   output port. It selects one requesting input, drives the one-hot crossbar
//   select, and runs the RTS/DCTS handshake toward the downstream router.
//   Optional packet locking (LOCK_PKT) and a burst cap (MAX_BURST).
//
// Parameters
//   NUM_PORTS  number of requesting inputs (>=2); index 0 = Local
//   LOCK_PKT   1: keep serving an input until its tail flit transfers
//   MAX_BURST  max consecutive transfers to one input while others wait
//              (0 = unlimited)
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   Req       in   per-input request level
//   Tail      in   per-input "current flit is the packet tail"
//   DCTS      in   downstream clear-to-send
//   RTS       out  registered request-to-send to downstream
//   Grant     out  one-hot pop strobe, only in the transfer cycle
//   Xbar_sel  out  one-hot crossbar select, zero when idle
// ---------------------------------------------------------------------------
module rr_arbiter_rts #(
  parameter int NUM_PORTS = 5,
  parameter int LOCK_PKT  = 0,
  parameter int MAX_BURST = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] Req,
  input  logic [NUM_PORTS-1:0] Tail,
  input  logic                 DCTS,
  output logic                 RTS,
  output logic [NUM_PORTS-1:0] Grant,
  output logic [NUM_PORTS-1:0] Xbar_sel
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  // Counter saturates at the cap; with no cap its value is never consulted.
  localparam logic [BW-1:0] BSAT = (MAX_BURST > 0) ? BW'(MAX_BURST) : {BW{1'b1}};

  logic [NUM_PORTS-1:0] cur_q, cur_d, nxt;
  logic                 rts_q, rts_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic                 lock_q, lock_d;
  logic                 fresh_q, fresh_d;   // entered cur, no transfer yet

  logic                 xfer, stall, locked, cap_hit, others, cur_tail;
  logic [PW-1:0]        cur_idx;

  // One-hot to index.
  function automatic logic [PW-1:0] enc(input logic [NUM_PORTS-1:0] oh);
    logic [PW-1:0] idx;
    idx = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (oh[k]) idx = PW'(k);
    end
    return idx;
  endfunction

  // (p + 1) mod NUM_PORTS.
  function automatic logic [PW-1:0] inc_mod(input logic [PW-1:0] p);
    return (p == PW'(NUM_PORTS - 1)) ? '0 : p + PW'(1);
  endfunction

  // First set bit of req searching upward from start, wrapping around.
  // Rotate so start lands at bit 0, take the lowest set bit, rotate back.
  function automatic logic [NUM_PORTS-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                   input logic [PW-1:0]        start);
    logic [2*NUM_PORTS-1:0] dbl;
    logic [2*NUM_PORTS-1:0] back;
    logic [NUM_PORTS-1:0]   rot;
    logic [NUM_PORTS-1:0]   pick;
    logic                   found;
    dbl   = {req, req} >> start;
    rot   = dbl[NUM_PORTS-1:0];
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!found && rot[k]) begin
        pick[k] = 1'b1;
        found   = 1'b1;
      end
    end
    back = {pick, pick} << start;
    return back[2*NUM_PORTS-1:NUM_PORTS];
  endfunction

  always_comb begin
    xfer     = rts_q & DCTS;
    stall    = rts_q & ~DCTS;
    cur_idx  = enc(cur_q);
    cur_tail = |(Tail & cur_q);
    others   = |(Req & ~cur_q);

    // In the transfer cycle the flit being popped decides the lock;
    // otherwise the lock holds after a non-tail flit or before the first flit.
    locked  = (LOCK_PKT != 0) && (cur_q != '0) &&
              (xfer ? ~cur_tail : (lock_q | fresh_q));
    cap_hit = (MAX_BURST > 0) && (bcnt_q == BSAT) && others;

    if (cur_q == '0) begin
      nxt = rr_pick(Req, inc_mod(ptr_q));
    end else if (locked) begin
      nxt = cur_q;
    end else if (cap_hit) begin
      nxt = rr_pick(Req, inc_mod(cur_idx));
    end else begin
      nxt = rr_pick(Req, cur_idx);
    end

    cur_d = stall ? cur_q : nxt;
    rts_d = (cur_q != '0) & ~xfer;
    ptr_d = (xfer && cur_q != '0) ? cur_idx : ptr_q;

    bcnt_d  = bcnt_q;
    lock_d  = lock_q;
    fresh_d = fresh_q;
    if (cur_d != cur_q) begin
      bcnt_d  = '0;
      lock_d  = 1'b0;
      fresh_d = (cur_d != '0);
    end else if (xfer) begin
      if (bcnt_q != BSAT) bcnt_d = bcnt_q + BW'(1);
      fresh_d = 1'b0;
      if (cur_q != '0) lock_d = ~cur_tail;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q   <= '0;
      rts_q   <= 1'b0;
      bcnt_q  <= '0;
      ptr_q   <= PW'(NUM_PORTS - 1);
      lock_q  <= 1'b0;
      fresh_q <= 1'b0;
    end else begin
      cur_q   <= cur_d;
      rts_q   <= rts_d;
      bcnt_q  <= bcnt_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      fresh_q <= fresh_d;
    end
  end

  assign RTS      = rts_q;
  assign Xbar_sel = cur_q;
  assign Grant    = cur_q & {NUM_PORTS{xfer}};

endmodule

// File: tb/tb_rr_arbiter_rts.sv
module tb_rr_arbiter_rts;
  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req, tail;
  logic         dcts;
  logic         rts_o [3];
  logic [N-1:0] g_o [3];
  logic [N-1:0] x_o [3];

  always #5 clk = ~clk;

  // 0: defaults, 1: burst cap 2, 2: packet lock
  rr_arbiter_rts #(.NUM_PORTS(N), .LOCK_PKT(0), .MAX_BURST(0)) dut0 (
    .clk(clk), .rst(rst), .Req(req), .Tail(tail), .DCTS(dcts),
    .RTS(rts_o[0]), .Grant(g_o[0]), .Xbar_sel(x_o[0]));
  rr_arbiter_rts #(.NUM_PORTS(N), .LOCK_PKT(0), .MAX_BURST(2)) dutb (
    .clk(clk), .rst(rst), .Req(req), .Tail(tail), .DCTS(dcts),
    .RTS(rts_o[1]), .Grant(g_o[1]), .Xbar_sel(x_o[1]));
  rr_arbiter_rts #(.NUM_PORTS(N), .LOCK_PKT(1), .MAX_BURST(0)) dutl (
    .clk(clk), .rst(rst), .Req(req), .Tail(tail), .DCTS(dcts),
    .RTS(rts_o[2]), .Grant(g_o[2]), .Xbar_sel(x_o[2]));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] t, input logic d);
    @(negedge clk);
    req = r; tail = t; dcts = d;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; tail = '0; dcts = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      check("reset_rts", N'(rts_o[c]), '0);
      check("reset_grant", g_o[c], '0);
      check("reset_xbar", x_o[c], '0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  int m_cur [3], m_ptr [3], m_bcnt [3];
  bit m_rts [3], m_lock [3], m_fresh [3];
  int cfg_lock  [3] = '{0, 0, 1};
  int cfg_burst [3] = '{0, 2, 0};

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] one;
    one = N'(1);
    return (i < 0) ? '0 : (one << i);
  endfunction

  function automatic int search(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      int j;
      logic [N-1:0] s;
      j = (start + k) % N;
      s = r >> j;
      if (s[0]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_cur[c] = -1; m_ptr[c] = N - 1; m_bcnt[c] = 0;
      m_rts[c] = 0; m_lock[c] = 0; m_fresh[c] = 0;
    end
  endtask

  task automatic model_step(input int c);
    bit xfer, stall, locked, tl;
    int cur, nxt, cap;
    logic [N-1:0] tsh;
    cur   = m_cur[c];
    xfer  = m_rts[c] && dcts;
    stall = m_rts[c] && !dcts;
    tsh   = (cur >= 0) ? (tail >> cur) : '0;
    tl    = tsh[0];
    nxt   = cur;
    if (!stall) begin
      if (cur < 0) nxt = search(req, (m_ptr[c] + 1) % N);
      else begin
        locked = (cfg_lock[c] != 0) && (xfer ? !tl : (m_lock[c] || m_fresh[c]));
        if (locked) nxt = cur;
        else if (cfg_burst[c] > 0 && m_bcnt[c] == cfg_burst[c] && (req & ~onehot(cur)) != '0)
          nxt = search(req, (cur + 1) % N);
        else nxt = search(req, cur);
      end
    end
    cap = (cfg_burst[c] > 0) ? cfg_burst[c] : 1;
    if (xfer && cur >= 0) m_ptr[c] = cur;
    if (nxt != cur) begin
      m_bcnt[c] = 0; m_lock[c] = 0; m_fresh[c] = (nxt >= 0);
    end else if (xfer) begin
      if (m_bcnt[c] < cap) m_bcnt[c]++;
      m_fresh[c] = 0;
      if (cur >= 0) m_lock[c] = !tl;
    end
    m_rts[c] = (cur >= 0) && !xfer;
    m_cur[c] = nxt;
  endtask

  // ---------------- table for the basic latency case ----------------
  typedef struct {
    logic [N-1:0] req;
    logic         dcts;
    logic         rts;
    logic [N-1:0] grant;
    logic [N-1:0] xbar;
  } vec_t;
  vec_t t1 [5];

  logic [N-1:0] got [8];
  logic [N-1:0] exp_burst [8];

  initial begin
    int ngot, cyc;
    t1[0] = '{req: 5'b00100, dcts: 1'b1, rts: 1'b0, grant: 5'b00000, xbar: 5'b00000};
    t1[1] = '{req: 5'b00100, dcts: 1'b1, rts: 1'b0, grant: 5'b00000, xbar: 5'b00100};
    t1[2] = '{req: 5'b00000, dcts: 1'b1, rts: 1'b1, grant: 5'b00100, xbar: 5'b00100};
    t1[3] = '{req: 5'b00000, dcts: 1'b1, rts: 1'b0, grant: 5'b00000, xbar: 5'b00000};
    t1[4] = '{req: 5'b00000, dcts: 1'b1, rts: 1'b0, grant: 5'b00000, xbar: 5'b00000};
    exp_burst = '{5'b00001, 5'b00001, 5'b00010, 5'b00010,
                  5'b00001, 5'b00001, 5'b00010, 5'b00010};
    rst = 1'b1; req = '0; tail = '0; dcts = 1'b0;

    // Basic latency: Xbar_sel at cycle 1, RTS+Grant at cycle 2, RTS low at 3.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(t1[i].req, '0, t1[i].dcts);
      check($sformatf("t1_rts[%0d]", i), N'(rts_o[0]), N'(t1[i].rts));
      check($sformatf("t1_grant[%0d]", i), g_o[0], t1[i].grant);
      check($sformatf("t1_xbar[%0d]", i), x_o[0], t1[i].xbar);
    end

    // All request: incumbent input 0 keeps the port; then drop Req[0].
    do_reset();
    drive(5'b11111, '0, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      drive(5'b11111, '0, 1'b1);
      check("all_xbar", x_o[0], 5'b00001);
      check("all_grant", g_o[0], (c % 2 == 0) ? 5'b00001 : 5'b00000);
    end
    ngot = 0;
    for (int c = 0; c < 10 && ngot == 0; c++) begin
      drive(5'b11110, '0, 1'b1);
      if (g_o[0] != '0) begin
        ngot = 1;
        check("drop0_grant", g_o[0], 5'b00010);
      end
    end
    if (ngot == 0) check("drop0_timeout", '0, 5'b00010);

    // Burst cap 2 with two requesters.
    do_reset();
    ngot = 0;
    cyc  = 0;
    while (ngot < 8 && cyc < 40) begin
      drive(5'b00011, '0, 1'b1);
      if (g_o[1] != '0) begin
        got[ngot] = g_o[1];
        ngot++;
      end
      cyc++;
    end
    if (ngot < 8) check("burst_timeout", N'(ngot), N'(8));
    for (int i = 0; i < ngot; i++) check($sformatf("burst_grant[%0d]", i), got[i], exp_burst[i]);

    // Stall: held on input 3 while Req changes, then release.
    do_reset();
    drive(5'b01000, '0, 1'b0);
    drive(5'b01000, '0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      drive(5'b00001, '0, 1'b0);
      check("stall_rts", N'(rts_o[0]), N'(1));
      check("stall_xbar", x_o[0], 5'b01000);
      check("stall_grant", g_o[0], 5'b00000);
    end
    drive(5'b00001, '0, 1'b1);
    check("unstall_grant", g_o[0], 5'b01000);
    drive(5'b00001, '0, 1'b1);
    check("unstall_xbar", x_o[0], 5'b00001);

    // Packet lock: input 1 keeps the port across a Req drop until its tail.
    do_reset();
    drive(5'b00110, 5'b00000, 1'b1);
    drive(5'b00110, 5'b00000, 1'b1);
    check("lock_xbar_c1", x_o[2], 5'b00010);
    drive(5'b00110, 5'b00000, 1'b1);
    check("lock_grant_f1", g_o[2], 5'b00010);
    drive(5'b00100, 5'b00000, 1'b1);
    check("lock_xbar_c3", x_o[2], 5'b00010);
    drive(5'b00100, 5'b00000, 1'b1);
    check("lock_grant_f2", g_o[2], 5'b00010);
    check("nolock_switch", x_o[0], 5'b00100);
    drive(5'b00100, 5'b00000, 1'b1);
    check("lock_xbar_c5", x_o[2], 5'b00010);
    drive(5'b00100, 5'b00010, 1'b1);
    check("lock_grant_tail", g_o[2], 5'b00010);
    drive(5'b00100, 5'b00000, 1'b1);
    check("lock_release", x_o[2], 5'b00100);

    // Asynchronous reset in the middle of a transfer cycle.
    do_reset();
    drive(5'b00001, '0, 1'b1);
    drive(5'b00001, '0, 1'b1);
    drive(5'b00001, '0, 1'b1);
    check("pre_arst_grant", g_o[0], 5'b00001);
    #1 rst = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      check("arst_rts", N'(rts_o[c]), '0);
      check("arst_grant", g_o[c], '0);
      check("arst_xbar", x_o[c], '0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Random traffic against the reference model, all three configurations.
    do_reset();
    model_reset();
    for (int cy = 0; cy < 600; cy++) begin
      drive(N'($urandom_range(0, 31)), N'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0));
      for (int c = 0; c < 3; c++) begin
        check($sformatf("rnd%0d_rts", c), N'(rts_o[c]), N'(m_rts[c]));
        check($sformatf("rnd%0d_xbar", c), x_o[c], onehot(m_cur[c]));
        check($sformatf("rnd%0d_grant", c), g_o[c],
              (m_rts[c] && dcts) ? onehot(m_cur[c]) : '0);
        check($sformatf("rnd%0d_onehot", c), N'($onehot0(g_o[c]) && $onehot0(x_o[c])), N'(1));
      end
      for (int c = 0; c < 3; c++) model_step(c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
